// File: rtl/sw_seq_feeder.sv
// Smith-Waterman input feeder: buffers 2-bit coded ref/query bases, replays them as one burst.
// Optional WAIT watchdog built when SW_FEED_TIMEOUT_EN is defined.
module sw_seq_feeder #(
  parameter int REF_LEN   = 64,
  parameter int QUERY_LEN = 48,
  parameter int TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic       in_is_query,
  input  logic       flush,
  output logic       sw_valid,
  output logic [1:0] sw_data_ref,
  output logic [1:0] sw_data_query,
  input  logic       sw_finish,
  output logic       busy,
  output logic       job_done,
  output logic       err_bad_char,
  output logic       err_timeout
);

  localparam int CW  = $clog2(REF_LEN + 1);
  localparam int QW  = $clog2(QUERY_LEN + 1);
  localparam int RAW = (REF_LEN > 1) ? $clog2(REF_LEN) : 1;
  localparam int QAW = (QUERY_LEN > 1) ? $clog2(QUERY_LEN) : 1;
  localparam logic [CW-1:0] REF_FULL  = CW'(REF_LEN);
  localparam logic [CW-1:0] REF_LAST  = CW'(REF_LEN - 1);
  localparam logic [CW-1:0] QRY_SPAN  = CW'(QUERY_LEN);
  localparam logic [QW-1:0] QRY_FULL  = QW'(QUERY_LEN);

  typedef enum logic [1:0] {LOAD, STREAM, WAIT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ref_cnt_q, ref_cnt_d;
  logic [QW-1:0]   qry_cnt_q, qry_cnt_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            sw_valid_q, sw_valid_d;
  logic [1:0]      ref_out_q, ref_out_d;
  logic [1:0]      qry_out_q, qry_out_d;
  logic            job_done_q, job_done_d;
  logic            err_bad_q, err_bad_d;
  logic [1:0]      ref_mem_q [REF_LEN];
  logic [1:0]      qry_mem_q [QUERY_LEN];

  logic            ref_full, qry_full, accept, wr_ref, wr_qry, bad;
  logic [1:0]      code;
  logic [CW-1:0]   idx_nxt;

  // Case-insensitive base code; anything else maps to 0 and is flagged.
  always_comb begin
    bad = 1'b0;
    case (in_char)
      8'h41, 8'h61: code = 2'd0;
      8'h43, 8'h63: code = 2'd1;
      8'h47, 8'h67: code = 2'd2;
      8'h54, 8'h74: code = 2'd3;
      default: begin code = 2'd0; bad = 1'b1; end
    endcase
  end

  assign ref_full = (ref_cnt_q == REF_FULL);
  assign qry_full = (qry_cnt_q == QRY_FULL);
  assign in_ready = (state_q == LOAD) & ~flush & ~(in_is_query ? qry_full : ref_full);
  assign accept   = in_valid & in_ready;
  assign wr_ref   = accept & ~in_is_query;
  assign wr_qry   = accept & in_is_query;
  assign idx_nxt  = idx_q + 1'b1;

`ifdef SW_FEED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_tmo_q, err_tmo_d;
  assign err_timeout = err_tmo_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ref_cnt_d  = ref_cnt_q;
    qry_cnt_d  = qry_cnt_q;
    idx_d      = idx_q;
    sw_valid_d = 1'b0;
    ref_out_d  = 2'd0;
    qry_out_d  = 2'd0;
    job_done_d = 1'b0;
    err_bad_d  = err_bad_q;
`ifdef SW_FEED_TIMEOUT_EN
    tmo_d      = tmo_q;
    err_tmo_d  = err_tmo_q;
`endif
    case (state_q)
      LOAD: begin
        if (flush) begin
          ref_cnt_d = '0;
          qry_cnt_d = '0;
          err_bad_d = 1'b0;
        end else if (ref_full && qry_full) begin
          // First burst beat is registered on the way into STREAM.
          state_d    = STREAM;
          idx_d      = '0;
          sw_valid_d = 1'b1;
          ref_out_d  = ref_mem_q[0];
          qry_out_d  = qry_mem_q[0];
        end else if (accept) begin
          if (in_is_query) qry_cnt_d = qry_cnt_q + 1'b1;
          else             ref_cnt_d = ref_cnt_q + 1'b1;
          if (bad) err_bad_d = 1'b1;
        end
      end
      STREAM: begin
        if (idx_q == REF_LAST) begin
          state_d = WAIT;
`ifdef SW_FEED_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          idx_d      = idx_nxt;
          sw_valid_d = 1'b1;
          ref_out_d  = ref_mem_q[idx_nxt[RAW-1:0]];
          if (idx_nxt < QRY_SPAN) qry_out_d = qry_mem_q[idx_nxt[QAW-1:0]];
        end
      end
      WAIT: begin
        if (sw_finish) begin
          state_d    = LOAD;
          job_done_d = 1'b1;
          ref_cnt_d  = '0;
          qry_cnt_d  = '0;
          err_bad_d  = 1'b0;
        end
`ifdef SW_FEED_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d   = LOAD;
          ref_cnt_d = '0;
          qry_cnt_d = '0;
          err_bad_d = 1'b0;
          err_tmo_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      ref_cnt_q  <= '0;
      qry_cnt_q  <= '0;
      idx_q      <= '0;
      sw_valid_q <= 1'b0;
      ref_out_q  <= 2'd0;
      qry_out_q  <= 2'd0;
      job_done_q <= 1'b0;
      err_bad_q  <= 1'b0;
`ifdef SW_FEED_TIMEOUT_EN
      tmo_q      <= '0;
      err_tmo_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ref_cnt_q  <= ref_cnt_d;
      qry_cnt_q  <= qry_cnt_d;
      idx_q      <= idx_d;
      sw_valid_q <= sw_valid_d;
      ref_out_q  <= ref_out_d;
      qry_out_q  <= qry_out_d;
      job_done_q <= job_done_d;
      err_bad_q  <= err_bad_d;
`ifdef SW_FEED_TIMEOUT_EN
      tmo_q      <= tmo_d;
      err_tmo_q  <= err_tmo_d;
`endif
    end
  end

  // Base storage needs no reset: counts gate every read.
  always_ff @(posedge clk) begin
    if (wr_ref) ref_mem_q[ref_cnt_q[RAW-1:0]] <= code;
    if (wr_qry) qry_mem_q[qry_cnt_q[QAW-1:0]] <= code;
  end

  assign sw_valid      = sw_valid_q;
  assign sw_data_ref   = ref_out_q;
  assign sw_data_query = qry_out_q;
  assign busy          = (state_q == STREAM) | (state_q == WAIT);
  assign job_done      = job_done_q;
  assign err_bad_char  = err_bad_q;

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Randomized self-checking bench for sw_seq_feeder against a load-order model of the burst.
module tb_sw_seq_feeder;
  localparam int RL = 64;
  localparam int QL = 48;
`ifdef SW_FEED_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic       clk = 1'b0, reset = 1'b1;
  logic       in_valid = 1'b0, in_is_query = 1'b0, flush = 1'b0, sw_finish = 1'b0;
  logic [7:0] in_char = 8'h0;
  logic       in_ready, sw_valid, busy, job_done, err_bad_char, err_timeout;
  logic [1:0] sw_data_ref, sw_data_query;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] rch [RL];
  logic [7:0] qch [QL];

  sw_seq_feeder #(.REF_LEN(RL), .QUERY_LEN(QL), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .in_is_query(in_is_query), .flush(flush), .sw_valid(sw_valid), .sw_data_ref(sw_data_ref),
    .sw_data_query(sw_data_query), .sw_finish(sw_finish), .busy(busy), .job_done(job_done),
    .err_bad_char(err_bad_char), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  function automatic logic [1:0] code_of(input logic [7:0] c);
    string s = "ACGT";
    logic [7:0] u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'd32 : c;
    for (int i = 0; i < 4; i++) if (s[i] == u) return i[1:0];
    return 2'd0;
  endfunction

  function automatic logic [7:0] rnd_base(input bit lower);
    string s = "ACGT";
    logic [7:0] c = s[$urandom_range(0, 3)];
    return lower ? c + 8'd32 : c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one char starting at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] c, input logic isq);
    int b = 0;
    in_char = c; in_is_query = isq; in_valid = 1'b1; #1;
    while (!in_ready && b < 50) begin @(negedge clk); #1; b++; end
    if (!in_ready) begin n_cmp++; n_bad++; $display("FAIL send_timeout: in_ready 0 expected 1"); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_job(input bit inter);
    int ri = 0, qi = 0;
    while (ri < RL || qi < QL) begin
      if (inter && $urandom_range(0, 2) == 0) begin @(negedge clk); continue; end
      if (ri < RL && (qi >= QL || !inter || $urandom_range(0, 1) == 1)) begin
        send(rch[ri], 1'b0); ri++;
      end else begin
        send(qch[qi], 1'b1); qi++;
      end
    end
  endtask

  task automatic check_burst(input string tag);
    int b = 0;
    logic [1:0] eq;
    while (!sw_valid && b < 20) begin @(negedge clk); b++; end
    n_cmp++;
    if (!sw_valid) begin
      n_bad++; $display("FAIL %s_start: sw_valid 0 expected 1", tag);
      return;
    end
    for (int k = 0; k < RL; k++) begin
      eq = (k < QL) ? code_of(qch[k]) : 2'd0;
      n_cmp++;
      if ({sw_valid, busy, sw_data_ref, sw_data_query} !== {2'b11, code_of(rch[k]), eq}) begin
        n_bad++;
        $display("FAIL %s_k%0d: v/busy/ref/q got %b%b %0d %0d expected 11 %0d %0d", tag, k,
                 sw_valid, busy, sw_data_ref, sw_data_query, code_of(rch[k]), eq);
      end
      @(negedge clk);
    end
    chk({tag, "_end_valid"}, {sw_valid, sw_data_ref, sw_data_query}, 0);
    chk({tag, "_wait_busy"}, busy, 1);
  endtask

  task automatic finish_job(input string tag);
    @(negedge clk); sw_finish = 1'b1;
    @(negedge clk); sw_finish = 1'b0; #1;
    chk({tag, "_job_done"}, job_done, 1);
    chk({tag, "_ready_back"}, {in_ready, busy, err_bad_char}, 3'b100);
    @(negedge clk);
    chk({tag, "_job_done_pulse"}, job_done, 0);
  endtask

  task automatic test_reset;
    #1;
    chk("reset_outputs", {in_ready, sw_valid, sw_data_ref, sw_data_query, busy, job_done,
                          err_bad_char, err_timeout}, 10'b10_0000_0000);
  endtask

  task automatic test_basic;
    string s = "ACGT";
    for (int i = 0; i < RL; i++) rch[i] = s[i % 4];
    for (int i = 0; i < QL; i++) qch[i] = "T";
    @(negedge clk); sw_finish = 1'b1;
    @(negedge clk); sw_finish = 1'b0;
    chk("finish_in_load_ignored", {job_done, busy}, 0);
    load_job(1'b0);
    check_burst("basic");
    chk("basic_err", err_bad_char, 0);
    finish_job("basic");
  endtask

  task automatic test_interleave;
    for (int i = 0; i < RL; i++) rch[i] = rnd_base(1'b1);
    for (int i = 0; i < QL; i++) qch[i] = rnd_base(1'b1);
    load_job(1'b1);
    check_burst("lower");
    chk("lower_err", err_bad_char, 0);
    finish_job("lower");
  endtask

  task automatic test_bad_char;
    for (int i = 0; i < RL; i++) rch[i] = rnd_base(1'b0);
    for (int i = 0; i < QL; i++) qch[i] = rnd_base(1'b0);
    rch[5] = 8'h4e;
    load_job(1'b1);
    check_burst("badchar");
    chk("badchar_err_wait", err_bad_char, 1);
    repeat (3) @(negedge clk);
    chk("badchar_err_sticky", err_bad_char, 1);
    finish_job("badchar");
  endtask

  task automatic test_overflow;
    for (int i = 0; i < RL; i++) rch[i] = rnd_base(1'b0);
    for (int i = 0; i < QL; i++) qch[i] = rnd_base(1'b0);
    for (int i = 0; i < RL; i++) send(rch[i], 1'b0);
    in_char = (code_of(rch[0]) == 2'd2) ? "T" : "G"; in_is_query = 1'b0; in_valid = 1'b1; #1;
    chk("ovf_ref_ready", in_ready, 0);
    @(negedge clk); #1;
    chk("ovf_ref_ready_hold", in_ready, 0);
    in_is_query = 1'b1; #1;
    chk("ovf_query_ready", in_ready, 1);
    in_valid = 1'b0;
    for (int i = 0; i < QL; i++) send(qch[i], 1'b1);
    check_burst("ovf");
    finish_job("ovf");
  endtask

  task automatic test_flush;
    for (int i = 0; i < 30; i++) send("C", 1'b0);
    for (int i = 0; i < 5; i++) send("g", 1'b1);
    send(8'h4e, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_char = "A"; in_is_query = 1'b0; #1;
    chk("flush_ready_low", in_ready, 0);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    chk("flush_err_clear", err_bad_char, 0);
    for (int i = 0; i < RL; i++) rch[i] = rnd_base(1'b0);
    for (int i = 0; i < QL; i++) qch[i] = rnd_base(1'b1);
    load_job(1'b1);
    check_burst("flush");
    finish_job("flush");
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < RL; i++) rch[i] = rnd_base(1'b0);
    for (int i = 0; i < QL; i++) qch[i] = rnd_base(1'b0);
    load_job(1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1; #1;
    chk("midreset_outputs", {sw_valid, busy, in_ready, job_done}, 4'b0010);
    @(negedge clk); reset = 1'b0;
  endtask

`ifdef SW_FEED_TIMEOUT_EN
  task automatic test_timeout;
    for (int i = 0; i < RL; i++) rch[i] = rnd_base(1'b0);
    for (int i = 0; i < QL; i++) qch[i] = rnd_base(1'b0);
    load_job(1'b1);
    check_burst("tmo");
    for (int n = 2; n <= TMO; n++) begin
      @(negedge clk);
      chk("tmo_pending", {err_timeout, busy, job_done}, 3'b010);
    end
    @(negedge clk);
    chk("tmo_fired", {err_timeout, busy, job_done, in_ready}, 4'b1001);
    repeat (3) @(negedge clk);
    chk("tmo_sticky", {err_timeout, job_done}, 2'b10);
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset;
    reset = 1'b0;
    test_basic;
    test_interleave;
    test_bad_char;
    test_overflow;
    test_flush;
    test_mid_reset;
    test_interleave;
`ifdef SW_FEED_TIMEOUT_EN
    test_timeout;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sw_seq_feeder.md
Name: sw_seq_feeder

Overview:
- Upstream stage of the Smith-Waterman scoring engine.
- Accepts ASCII nucleotide characters for one reference and one query sequence over a valid/ready handshake, encodes them to 2 bits and buffers them.
- Replays them to the engine as one contiguous serial burst: sw_valid high, ref base and query base per cycle.
- Holds off the next job until the engine pulses finish.

Parameters:
- REF_LEN, 64, reference bases per job; sets the burst length. Must be >= QUERY_LEN.
- QUERY_LEN, 48, query bases per job.
- TIMEOUT, 1024, WAIT-state watchdog limit in cycles. Used only with SW_FEED_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  character offered
- in_ready  out  1  character accepted this cycle when in_valid & in_ready
- in_char  in  8  ASCII base
- in_is_query  in  1  0 = reference buffer, 1 = query buffer
- flush  in  1  synchronous; discards partially loaded job (LOAD state only)
- sw_valid  out  1  to engine valid
- sw_data_ref  out  2  to engine data_ref
- sw_data_query  out  2  to engine data_query
- sw_finish  in  1  from engine finish
- busy  out  1  high in STREAM and WAIT
- job_done  out  1  one-cycle pulse when sw_finish is seen in WAIT
- err_bad_char  out  1  sticky: an illegal character was accepted in the current job
- err_timeout  out  1  sticky watchdog flag; constant 0 when the macro is absent

Behaviour:
- Reset values: state LOAD, ref_cnt = query_cnt = 0, stream index 0. All outputs 0, except in_ready = 1 (combinational).
- Encoding: 'A'/'a' = 0, 'C'/'c' = 1, 'G'/'g' = 2, 'T'/'t' = 3. Any other byte is stored as 0 and sets err_bad_char.
- in_ready = (state == LOAD) & !flush & !(in_is_query ? query_cnt == QUERY_LEN : ref_cnt == REF_LEN). It is combinational on in_is_query.
- Handshake writes: buffer[cnt] <= code; cnt++. Characters of the two sequences may interleave in any order.
- A write to a full buffer stalls (in_ready = 0) and does not drop data.
- LOAD -> STREAM: on the edge after both counts reach full.
- STREAM, index k = 0 .. REF_LEN-1, registered outputs:
  - sw_valid = 1
  - sw_data_ref = ref[k]
  - sw_data_query = (k < QUERY_LEN) ? query[k] : 0
  - sw_valid is high for exactly REF_LEN consecutive cycles with no gaps. The first high cycle is the first cycle spent in STREAM.
  - Base order is load order: first loaded base is presented first.
- STREAM -> WAIT: after the k = REF_LEN-1 cycle. sw_valid and data drop to 0 on that edge.
- WAIT: sw_valid held 0. When sw_finish = 1:
  - job_done pulses on the next cycle.
  - Counts clear, err_bad_char clears, state returns to LOAD.
  - sw_finish seen outside WAIT is ignored.
- flush: honoured in LOAD only. Clears counts and err_bad_char. Flush wins over a simultaneous handshake, since in_ready is forced low.
- Reset mid-job (any state) aborts immediately to reset values. The engine must be reset alongside it.
- Minimum sw_valid low gap between bursts: WAIT duration + REF_LEN + QUERY_LEN load cycles. The engine always observes valid falling.
- busy = (state == STREAM) | (state == WAIT).

Optional Feature:
- Macro: SW_FEED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If TIMEOUT cycles pass without sw_finish, err_timeout sets (sticky, cleared only by reset) and state returns to LOAD with counts cleared.
  - job_done is not pulsed.
- Undefined: no counter is built, err_timeout is tied 0, and WAIT waits indefinitely.

Test Plan:
- Load 64 ref chars "ACGT" repeated and 48 query "TTTT...". Response:
  - sw_valid high exactly 64 cycles.
  - sw_data_ref sequence 0,1,2,3,0,...
  - sw_data_query = 3 for k < 48, then 0 for k = 48..63.
- Interleave ref/query chars, lowercase "acgt", in_valid toggled randomly. Response: identical burst to the uppercase equivalent; err_bad_char = 0.
- Send 'N' (0x4E) as ref base 5. Response: sw_data_ref = 0 at k = 5; err_bad_char = 1 until sw_finish is seen.
- After 64 ref chars, offer a 65th ref char. Response: in_ready = 0, it is not stored, and query loading continues.
- Load 30 ref chars, assert flush, then load a full job. Response: the burst contains only post-flush data. Pulse sw_finish in WAIT: job_done is high for 1 cycle and in_ready returns.
- With SW_FEED_TIMEOUT_EN and TIMEOUT = 16, never pulse sw_finish. Response: 16 cycles after entering WAIT, err_timeout = 1, state LOAD, no job_done.
